dpram_arb: RTL

DPRAM_ARB -- requirements
Module: dpram_arb

---
 rtl/dpram_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dpram_arb.sv
// Two-requester arbiter in front of a simple dual-port RAM with independent
// write-port and read-port round-robin. Optional feature: DPRAM_ARB_WR_BYPASS_EN.
module dpram_arb #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_wraddr,
  output logic [DATA_WIDTH-1:0] ram_wrdata,
  output logic [ADDR_WIDTH-1:0] ram_rdaddr,
  input  logic [DATA_WIDTH-1:0] ram_rddata
);

  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } fav_e;

  fav_e                  wr_fav;
  fav_e                  rd_fav;
  logic                  a_wreq, b_wreq, a_rreq, b_rreq;
  logic                  wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
  logic                  wr_contend, rd_contend;
  logic [ADDR_WIDTH-1:0] wraddr_q, rdaddr_q;
  logic [DATA_WIDTH-1:0] wrdata_q;
  logic                  a_rv_q, b_rv_q;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Requests are masked by rst_n so grants stay low for the whole reset.
  always_comb begin
    a_wreq     = a_valid & a_wr & rst_n;
    b_wreq     = b_valid & b_wr & rst_n;
    a_rreq     = a_valid & ~a_wr & rst_n;
    b_rreq     = b_valid & ~b_wr & rst_n;
    wr_contend = a_wreq & b_wreq;
    rd_contend = a_rreq & b_rreq;
    wr_gnt_a   = a_wreq & (~b_wreq | (wr_fav == FAV_A));
    wr_gnt_b   = b_wreq & (~a_wreq | (wr_fav == FAV_B));
    rd_gnt_a   = a_rreq & (~b_rreq | (rd_fav == FAV_A));
    rd_gnt_b   = b_rreq & (~a_rreq | (rd_fav == FAV_B));
  end

  always_comb begin
    a_ready  = wr_gnt_a | rd_gnt_a;
    b_ready  = wr_gnt_b | rd_gnt_b;
    ram_wren = wr_gnt_a | wr_gnt_b;
    if (wr_gnt_a) begin
      ram_wraddr = a_addr;
      ram_wrdata = a_wdata;
    end else if (wr_gnt_b) begin
      ram_wraddr = b_addr;
      ram_wrdata = b_wdata;
    end else begin
      ram_wraddr = wraddr_q;
      ram_wrdata = wrdata_q;
    end
    if (rd_gnt_a)      ram_rdaddr = a_addr;
    else if (rd_gnt_b) ram_rdaddr = b_addr;
    else               ram_rdaddr = rdaddr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_fav   <= FAV_A;
      rd_fav   <= FAV_A;
      wraddr_q <= '0;
      wrdata_q <= '0;
      rdaddr_q <= '0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      // Pointers move only when both requesters competed for the port.
      if (wr_contend) wr_fav <= wr_gnt_a ? FAV_B : FAV_A;
      if (rd_contend) rd_fav <= rd_gnt_a ? FAV_B : FAV_A;
      wraddr_q <= ram_wraddr;
      wrdata_q <= ram_wrdata;
      rdaddr_q <= ram_rdaddr;
      a_rv_q   <= rd_gnt_a;
      b_rv_q   <= rd_gnt_b;
    end
  end

`ifdef DPRAM_ARB_WR_BYPASS_EN
  logic                  byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  // Same-cycle read/write collision: the RAM returns old data, so forward the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= ram_wren & (rd_gnt_a | rd_gnt_b) & (ram_wraddr == ram_rdaddr);
      byp_data_q <= ram_wrdata;
    end
  end

  always_comb rsp_data = byp_hit_q ? byp_data_q : ram_rddata;
`else
  always_comb rsp_data = ram_rddata;
`endif

  always_comb begin
    a_rvalid = a_rv_q;
    b_rvalid = b_rv_q;
    a_rdata  = a_rv_q ? rsp_data : '0;
    b_rdata  = b_rv_q ? rsp_data : '0;
  end

endmodule
